// File: rtl/mem_access_unit_if.sv
// Load/store bus between the control/datapath side and the memory access unit.
// The slave modport is the unit; the master side owns both the CPU and memory ends.
interface mem_access_unit_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    modport slave (
        input  req, wr, size, sign_ext, addr, wdata, mem_rd,
        output ready, done, err, rdata, mem_a, mem_wd, mem_we
    );

    modport master (
        output req, wr, size, sign_ext, addr, wdata, mem_rd,
        input  ready, done, err, rdata, mem_a, mem_wd, mem_we
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multicycle load/store unit: byte/half/word loads with extension,
// sub-word stores by read-modify-write, misalignment detection.
module mem_access_unit (
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;

    logic        bad;
    logic [4:0]  lane_sh;
    logic [31:0] rd_sh;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] wr_sh;

    assign bad = (bus.size == 2'b11)
               | ((bus.size == 2'b01) & bus.addr[0])
               | ((bus.size == 2'b10) & (|bus.addr[1:0]));

    assign lane_sh = {addr_q[1:0], 3'b000};
    assign rd_sh   = bus.mem_rd >> lane_sh;
    assign wr_sh   = wdata_q << lane_sh;

    always_comb begin
        load_val  = bus.mem_rd;
        lane_mask = 32'hFFFF_FFFF;
        unique case (size_q)
            2'b00: begin
                load_val  = {{24{sign_q & rd_sh[7]}}, rd_sh[7:0]};
                lane_mask = 32'h0000_00FF << lane_sh;
            end
            2'b01: begin
                load_val  = {{16{sign_q & rd_sh[15]}}, rd_sh[15:0]};
                lane_mask = 32'h0000_FFFF << lane_sh;
            end
            default: begin
                load_val  = bus.mem_rd;
                lane_mask = 32'hFFFF_FFFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Word stores skip the read; every other legal access reads first.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (bad) begin
                        state_d = DONE;
                    end else if (!bus.wr || bus.size != 2'b10) begin
                        state_d = RD;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            RD:      state_d = wr_q ? WR : DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready  = (state_q == IDLE);
        bus.done   = (state_q == DONE);
        bus.err    = (state_q == DONE) & err_q;
        bus.mem_we = (state_q == WR);
        bus.mem_a  = {addr_q[31:2], 2'b00};
        bus.mem_wd = (merge_q & ~lane_mask) | (wr_sh & lane_mask);
        bus.rdata  = rdata_q;
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sign_d  = sign_q;
        wr_d    = wr_q;
        err_d   = err_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        if (state_q == IDLE && bus.req) begin
            addr_d  = bus.addr;
            wdata_d = bus.wdata;
            size_d  = bus.size;
            sign_d  = bus.sign_ext;
            wr_d    = bus.wr;
            err_d   = bad;
        end
        if (state_q == RD) begin
            if (wr_q) begin
                merge_d = bus.mem_rd;
            end else begin
                rdata_d = load_val;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized traffic
// checked against a word-array model of memory and the load register.
module tb_mem_access_unit;
    logic clk;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    mem_access_unit_if bus();

    mem_access_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic [31:0] ref_rdata;

    assign bus.mem_rd = mem[bus.mem_a[7:2]];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[7:2]] <= bus.mem_wd;

    function automatic bit ref_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) ||
               (sz == 2'b10 && a % 4 != 0);
    endfunction

    function automatic int ref_lat(input bit w, input logic [1:0] sz,
                                   input logic [31:0] a);
        if (ref_bad(sz, a)) return 1;
        if (!w) return 2;
        if (sz == 2'b10) return 2;
        return 3;
    endfunction

    task automatic ref_apply(input bit w, input logic [1:0] sz, input bit sg,
                             input logic [31:0] a, input logic [31:0] d);
        int     idx;
        longint old, m, lane, sh;
        if (ref_bad(sz, a)) return;
        idx  = int'(a[7:2]);
        old  = longint'(ref_mem[idx]);
        m    = (sz == 2'b00) ? 64'd256 : (sz == 2'b01) ? 64'd65536 : 64'h1_0000_0000;
        sh   = (sz == 2'b10) ? 0 : 8 * longint'(a % 4);
        lane = (old >> sh) % m;
        if (!w) begin
            if (sg && lane >= m / 2) lane = lane - m;
            ref_rdata = lane[31:0];
        end else begin
            old = old - (lane << sh) + ((longint'(d) % m) << sh);
            ref_mem[idx] = old[31:0];
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        mem[idx]     = v;
        ref_mem[idx] = v;
    endtask

    task automatic access(input bit w, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output bit e, output int we_n,
                          output logic [31:0] we_a);
        bit got;
        @(negedge clk);
        bus.req = 1'b1; bus.wr = w; bus.size = sz;
        bus.sign_ext = sg; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        #1 bus.req = 1'b0;
        lat = 0; e = 1'b0; we_n = 0; we_a = '0; got = 1'b0;
        for (int n = 1; n <= 8 && !got; n++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                we_n++;
                we_a = bus.mem_a;
            end
            if (bus.done) begin
                lat = n;
                e   = bus.err;
                got = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if (bus.ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
        tests_run++;
        if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.mem_we !== 1'b0) begin
            tests_failed++; $display("FAIL reset_flags: done=%b err=%b we=%b expected 0", bus.done, bus.err, bus.mem_we);
        end
        tests_run++;
        if (bus.rdata !== 32'h0 || bus.mem_a !== 32'h0 || bus.mem_wd !== 32'h0) begin
            tests_failed++; $display("FAIL reset_regs: rdata=%h mem_a=%h mem_wd=%h expected 0", bus.rdata, bus.mem_a, bus.mem_wd);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_word();
        int lat, we_n; bit e; logic [31:0] we_a;
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, e, we_n, we_a);
        ref_apply(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        tests_run++;
        if (lat !== 2 || e !== 1'b0) begin tests_failed++; $display("FAIL sw_lat: got lat=%0d err=%b expected 2/0", lat, e); end
        tests_run++;
        if (we_n !== 1 || we_a !== 32'h10) begin tests_failed++; $display("FAIL sw_we: got %0d cycles at %h expected 1 at 10", we_n, we_a); end
        tests_run++;
        if (mem[4] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL sw_mem: got %h expected deadbeef", mem[4]); end
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, we_n, we_a);
        ref_apply(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        tests_run++;
        if (lat !== 2 || e !== 1'b0 || we_n !== 0) begin tests_failed++; $display("FAIL lw_lat: got lat=%0d err=%b we=%0d expected 2/0/0", lat, e, we_n); end
        tests_run++;
        if (bus.rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_data: got %h expected deadbeef", bus.rdata); end
    endtask

    task automatic test_byte_loads();
        logic [31:0] ta [5] = '{32'h11, 32'h13, 32'h12, 32'h12, 32'h12};
        logic [1:0]  ts [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        bit          tg [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] te [5] = '{32'h7F, 32'hFFFFFF80, 32'hFF, 32'hFFFF80FF, 32'h80FF};
        int lat, we_n; bit e; logic [31:0] we_a;
        poke(4, 32'h80FF7F01);
        for (int i = 0; i < 5; i++) begin
            access(1'b0, ts[i], tg[i], ta[i], 32'h0, lat, e, we_n, we_a);
            ref_apply(1'b0, ts[i], tg[i], ta[i], 32'h0);
            tests_run++;
            if (bus.rdata !== te[i] || lat !== 2 || e !== 1'b0) begin
                tests_failed++;
                $display("FAIL subload_%0d: got %h lat=%0d err=%b expected %h lat=2 err=0", i, bus.rdata, lat, e, te[i]);
            end
        end
    endtask

    task automatic test_subword_store();
        int lat, we_n; bit e; logic [31:0] we_a;
        poke(8, 32'h11223344);
        access(1'b1, 2'b00, 1'b0, 32'h21, 32'h123456AA, lat, e, we_n, we_a);
        ref_apply(1'b1, 2'b00, 1'b0, 32'h21, 32'h123456AA);
        tests_run++;
        if (lat !== 3 || e !== 1'b0 || we_n !== 1) begin tests_failed++; $display("FAIL sb_lat: got lat=%0d err=%b we=%0d expected 3/0/1", lat, e, we_n); end
        tests_run++;
        if (mem[8] !== 32'h1122AA44) begin tests_failed++; $display("FAIL sb_mem: got %h expected 1122aa44", mem[8]); end
        access(1'b1, 2'b01, 1'b0, 32'h22, 32'h5555BEEF, lat, e, we_n, we_a);
        ref_apply(1'b1, 2'b01, 1'b0, 32'h22, 32'h5555BEEF);
        tests_run++;
        if (lat !== 3 || mem[8] !== 32'hBEEFAA44) begin tests_failed++; $display("FAIL sh_mem: got %h lat=%0d expected beefaa44 lat=3", mem[8], lat); end
    endtask

    task automatic test_misalign();
        logic [31:0] ta [3] = '{32'h21, 32'h22, 32'h20};
        logic [1:0]  ts [3] = '{2'b01, 2'b10, 2'b11};
        int lat, we_n; bit e; logic [31:0] we_a;
        for (int i = 0; i < 3; i++) begin
            access(1'b1, ts[i], 1'b0, ta[i], 32'hFFFFFFFF, lat, e, we_n, we_a);
            ref_apply(1'b1, ts[i], 1'b0, ta[i], 32'hFFFFFFFF);
            tests_run++;
            if (lat !== 1 || e !== 1'b1 || we_n !== 0) begin
                tests_failed++; $display("FAIL misalign_%0d: got lat=%0d err=%b we=%0d expected 1/1/0", i, lat, e, we_n);
            end
            tests_run++;
            if (mem[8] !== ref_mem[8] || bus.rdata !== ref_rdata) begin
                tests_failed++; $display("FAIL misalign_state_%0d: got mem=%h rdata=%h expected %h %h", i, mem[8], bus.rdata, ref_mem[8], ref_rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 12;
        bit          qw [N];
        logic [1:0]  qs [N];
        bit          qg [N];
        logic [31:0] qa [N];
        logic [31:0] qd [N];
        int acc, dn, extra, cyc;
        logic [31:0] r;
        for (int i = 0; i < N; i++) begin
            r     = $urandom();
            qw[i] = (i % 2 == 0);
            qs[i] = 2'($urandom_range(0, 3));
            qg[i] = r[0];
            qa[i] = {24'h0, 2'b01, r[5:0]};
            qd[i] = $urandom();
        end
        acc = 0; dn = 0; extra = 0; cyc = 0;
        while (dn < N && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                ref_apply(qw[dn], qs[dn], qg[dn], qa[dn], qd[dn]);
                tests_run++;
                if (bus.err !== ref_bad(qs[dn], qa[dn]) || bus.rdata !== ref_rdata) begin
                    tests_failed++;
                    $display("FAIL b2b_%0d: got err=%b rdata=%h expected err=%b rdata=%h", dn, bus.err, bus.rdata, ref_bad(qs[dn], qa[dn]), ref_rdata);
                end
                dn++;
            end
            if (bus.ready) begin
                if (acc < N) begin
                    bus.req = 1'b1; bus.wr = qw[acc]; bus.size = qs[acc];
                    bus.sign_ext = qg[acc]; bus.addr = qa[acc]; bus.wdata = qd[acc];
                    acc++;
                end else begin
                    bus.req = 1'b0;
                end
            end
        end
        bus.req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        tests_run++;
        if (dn !== N || acc !== N || extra !== 0) begin
            tests_failed++; $display("FAIL b2b_count: got done=%0d acc=%0d extra=%0d expected %0d %0d 0", dn, acc, extra, N, N);
        end
        tests_run++;
        for (int i = 16; i < 32; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                tests_failed++; $display("FAIL b2b_mem: word %0d got %h expected %h", i, mem[i], ref_mem[i]);
                break;
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, we_n; bit e; logic [31:0] we_a;
        for (int phase = 0; phase < 2; phase++) begin
            poke(12, 32'hCAFEBABE);
            access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, we_n, we_a);
            ref_apply(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
            @(negedge clk);
            bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'b00;
            bus.sign_ext = 1'b0; bus.addr = 32'h30; bus.wdata = 32'h55;
            @(posedge clk);
            #1 bus.req = 1'b0;
            @(negedge clk);
            if (phase == 1) begin
                @(negedge clk);
                tests_run++;
                if (bus.mem_we !== 1'b1) begin tests_failed++; $display("FAIL rst_wr_reach: got we=%b expected 1", bus.mem_we); end
            end
            reset = 1'b0;
            #1;
            ref_rdata = 32'h0;
            tests_run++;
            if (bus.mem_we !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
                tests_failed++; $display("FAIL rst_mid_%0d: got we=%b ready=%b done=%b expected 0 1 0", phase, bus.mem_we, bus.ready, bus.done);
            end
            tests_run++;
            if (bus.rdata !== ref_rdata) begin tests_failed++; $display("FAIL rst_rdata_%0d: got %h expected 0", phase, bus.rdata); end
            @(posedge clk);
            #1;
            tests_run++;
            if (mem[12] !== 32'hCAFEBABE) begin tests_failed++; $display("FAIL rst_nowrite_%0d: got %h expected cafebabe", phase, mem[12]); end
            @(negedge clk);
            reset = 1'b1;
        end
    endtask

    task automatic test_random();
        int lat, we_n, idx; bit e; logic [31:0] we_a, a, d, r;
        bit w, g; logic [1:0] s;
        for (int i = 0; i < 30; i++) begin
            r = $urandom();
            a = {r[31:8], 2'b00, 6'($urandom_range(0, 63))};
            a[1:0] = r[1:0];
            d = $urandom();
            w = r[2];
            g = r[3];
            s = 2'($urandom_range(0, 3));
            idx = int'(a[7:2]);
            access(w, s, g, a, d, lat, e, we_n, we_a);
            ref_apply(w, s, g, a, d);
            tests_run++;
            if (lat !== ref_lat(w, s, a) || e !== ref_bad(s, a)) begin
                tests_failed++; $display("FAIL rnd_lat_%0d: got lat=%0d err=%b expected %0d %b", i, lat, e, ref_lat(w, s, a), ref_bad(s, a));
            end
            tests_run++;
            if (we_n !== ((w && !ref_bad(s, a)) ? 1 : 0) || (we_n == 1 && we_a !== {a[31:2], 2'b00})) begin
                tests_failed++; $display("FAIL rnd_we_%0d: got %0d cycles at %h for addr %h", i, we_n, we_a, a);
            end
            tests_run++;
            if (bus.rdata !== ref_rdata || mem[idx] !== ref_mem[idx]) begin
                tests_failed++; $display("FAIL rnd_data_%0d: got rdata=%h mem=%h expected %h %h", i, bus.rdata, mem[idx], ref_rdata, ref_mem[idx]);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'b00;
        bus.sign_ext = 1'b0; bus.addr = '0; bus.wdata = '0;
        ref_rdata = 32'h0;
        for (int i = 0; i < 64; i++) poke(i, $urandom());
        test_reset();
        test_word();
        test_byte_loads();
        test_subword_store();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
